data_mem_sync: RTL and testbench

Parametrised, synchronous successor to the 16-bit data memory.
- Adds configurable data/address width and depth, byte-lane write enables, and registered reads with a valid strobe.
- A request/ready handshake lets the memory zero itself after reset.
- Sits between the ALU address path and the register-file writeback mux of the processor.

---
 rtl/data_mem_sync.sv | 124 ++++++++++++
 tb/tb_data_mem_sync.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sync.sv
// Synchronous word memory with byte-lane writes, registered reads and a
// self-clearing sequence after reset that holds ready low until every word is zero.
module data_mem_sync #(
   parameter  int unsigned DATA_W = 16,
   parameter  int unsigned ADDR_W = 16,
   parameter  int unsigned DEPTH  = 65536,
   localparam int unsigned NBE    = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              wflag,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] datain,
   input  logic [NBE-1:0]    be,
   output logic              ready,
   output logic [DATA_W-1:0] dataout,
   output logic              rvalid,
   output logic              err
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   typedef enum logic [0:0] {StClear, StIdle} state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] dataout_q;
   logic              rvalid_q, err_q;

   logic              clearing;
   logic              acc, rd_acc, in_range;
   logic [PTR_W-1:0]  word_idx;
   logic [NBE-1:0]    mem_be;
   logic [PTR_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Extra top bit keeps the compare meaningful when DEPTH == 2^ADDR_W.
   assign in_range = ({1'b0, addr} < DEPTH_X);
   assign word_idx = addr[PTR_W-1:0];
   assign acc      = req && ready;
   assign rd_acc   = acc && !wflag;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StClear;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         StClear: begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_PTR) begin
               state_d   = StIdle;
               clr_ptr_d = '0;
            end
         end
         StIdle:  state_d = StIdle;
         default: state_d = StClear;
      endcase
   end

   always_comb begin
      ready    = 1'b0;
      clearing = 1'b0;
      unique case (state_q)
         StClear: clearing = 1'b1;
         StIdle:  ready    = 1'b1;
         default: clearing = 1'b0;
      endcase
   end

   // Single write port shared by the clear sequence and accepted writes.
   always_comb begin
      if (clearing) begin
         mem_be    = '1;
         mem_waddr = clr_ptr_q;
         mem_wdata = '0;
      end else begin
         mem_be    = (acc && wflag && in_range) ? be : '0;
         mem_waddr = word_idx;
         mem_wdata = datain;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NBE; i++) begin
            if (mem_be[i]) begin
               mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dataout_q <= '0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rvalid_q <= rd_acc;
         err_q    <= acc && !in_range;
         if (rd_acc) begin
            dataout_q <= in_range ? mem_q[word_idx] : '0;
         end
      end
   end

   assign dataout = dataout_q;
   assign rvalid  = rvalid_q;
   assign err     = err_q;

endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: behavioural memory model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_data_mem_sync;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 16;

   logic          clk    = 1'b0;
   logic          rst    = 1'b1;
   logic          req    = 1'b0;
   logic          wflag  = 1'b0;
   logic [AW-1:0] addr   = '0;
   logic [DW-1:0] datain = '0;
   logic [1:0]    be     = '0;
   logic          ready, rvalid, err;
   logic [DW-1:0] dataout;

   always #5 clk = ~clk;

   data_mem_sync #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wflag   (wflag),
      .addr    (addr),
      .datain  (datain),
      .be      (be),
      .ready   (ready),
      .dataout (dataout),
      .rvalid  (rvalid),
      .err     (err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: memory array, cycles-since-reset counter for the clear phase.
   logic [DW-1:0] m [DEPTH];
   int unsigned   since      = 0;
   logic          exp_rvalid = 1'b0;
   logic          exp_err    = 1'b0;
   logic [DW-1:0] exp_dout   = '0;
   logic          exp_ready;

   assign exp_ready = (since >= DEPTH);

   always @(posedge clk) begin
      if (rst) begin
         since      <= 0;
         exp_rvalid <= 1'b0;
         exp_err    <= 1'b0;
         exp_dout   <= '0;
      end else if (since < DEPTH) begin
         m[since[3:0]] <= '0;
         since         <= since + 1;
         exp_rvalid    <= 1'b0;
         exp_err       <= 1'b0;
      end else begin
         exp_rvalid <= req && !wflag;
         exp_err    <= req && (addr >= DEPTH);
         if (req && !wflag) exp_dout <= (addr < DEPTH) ? m[addr[3:0]] : '0;
         if (req && wflag && (addr < DEPTH))
            m[addr[3:0]] <= {be[1] ? datain[15:8] : m[addr[3:0]][15:8],
                             be[0] ? datain[7:0]  : m[addr[3:0]][7:0]};
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("ready", {31'd0, ready}, {31'd0, exp_ready});
         chk("rvalid", {31'd0, rvalid}, {31'd0, exp_rvalid});
         chk("err", {31'd0, err}, {31'd0, exp_err});
         chk("dataout", {16'd0, dataout}, {16'd0, exp_dout});
      end
   end

   task automatic idle();
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      wflag = 1'($urandom); addr = AW'($urandom); datain = DW'($urandom); be = 2'($urandom);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
      @(negedge clk);
      req = 1'b1; wflag = 1'b1; addr = a; datain = d; be = b;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      @(negedge clk);
      req = 1'b1; wflag = 1'b0; addr = a; datain = DW'($urandom); be = 2'($urandom);
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      rst = 1'b1; req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Counts cycles until ready rises; optionally keeps hammering a write to word 3.
   task automatic count_clear(input bit poke, output int n);
      n = 0;
      while (!ready && n < 200) begin
         req = poke; wflag = 1'b1; addr = 8'd3; datain = 16'h7777; be = 2'b11;
         @(negedge clk);
         n++;
      end
      req = 1'b0;
   endtask

   int n;

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_en = 1'b1;
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_dataout", {16'd0, dataout}, 32'd0);
      count_clear(1'b0, n);
      chk("init_clear_cycles", n, 32'd16);

      // Fill with ones, reset, expect every word cleared.
      for (int i = 0; i < DEPTH; i++) wr(AW'(i), 16'hFFFF, 2'b11);
      rst_pulse();
      count_clear(1'b0, n);
      chk("clear_cycles", n, 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         rd(AW'(i));
         if (i > 0) begin
            chk("clear_data", {16'd0, dataout}, 32'd0);
            chk("clear_rvalid", {31'd0, rvalid}, 32'd1);
         end
      end
      idle();
      chk("clear_data_last", {16'd0, dataout}, 32'd0);

      wr(8'd5, 16'hA5C3, 2'b11);
      rd(8'd5);
      idle();
      chk("full_word", {16'd0, dataout}, 32'hA5C3);
      chk("full_word_rvalid", {31'd0, rvalid}, 32'd1);

      wr(8'd7, 16'h1234, 2'b11);
      wr(8'd7, 16'hABCD, 2'b01);
      rd(8'd7);
      idle();
      chk("lane0", {16'd0, dataout}, 32'h12CD);
      wr(8'd7, 16'hEF00, 2'b10);
      rd(8'd7);
      idle();
      chk("lane1", {16'd0, dataout}, 32'hEFCD);

      wr(8'd1, 16'h0011, 2'b11);
      wr(8'd2, 16'h0022, 2'b11);
      wr(8'd3, 16'h0033, 2'b11);
      rd(8'd1);
      rd(8'd2);
      chk("b2b_0", {15'd0, rvalid, dataout}, 32'h10011);
      rd(8'd3);
      chk("b2b_1", {15'd0, rvalid, dataout}, 32'h10022);
      wr(8'd9, 16'hBEEF, 2'b11);
      chk("b2b_2", {15'd0, rvalid, dataout}, 32'h10033);
      rd(8'd9);
      idle();
      chk("raw", {16'd0, dataout}, 32'hBEEF);
      idle();
      chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
      chk("dataout_hold", {16'd0, dataout}, 32'hBEEF);

      wr(8'd4, 16'h0404, 2'b11);
      rd(8'd20);
      idle();
      chk("oor_rd", {14'd0, err, rvalid, dataout}, 32'h30000);
      wr(8'd20, 16'h5555, 2'b11);
      idle();
      chk("oor_wr", {30'd0, err, rvalid}, 32'd2);
      rd(8'd4);
      idle();
      chk("no_wrap", {16'd0, dataout}, 32'h0404);

      // Requests during clear are ignored; reset mid-clear restarts the full clear.
      rst_pulse();
      repeat (8) begin
         req = 1'b1; wflag = 1'b1; addr = 8'd3; datain = 16'h7777; be = 2'b11;
         @(negedge clk);
      end
      chk("mid_clear_ready", {31'd0, ready}, 32'd0);
      rst = 1'b1; req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      count_clear(1'b1, n);
      chk("restart_clear_cycles", n, 32'd16);
      rd(8'd3);
      idle();
      chk("clear_ignores_req", {16'd0, dataout}, 32'd0);

      repeat (3000) begin
         @(negedge clk);
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1; req = 1'b0;
         end else begin
            rst    = 1'b0;
            req    = ($urandom_range(0, 2) != 0);
            wflag  = 1'($urandom);
            addr   = AW'($urandom_range(0, 23));
            datain = DW'($urandom);
            be     = 2'($urandom);
         end
      end
      repeat (20) idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
